// File: rtl/cache_stage.sv
// cache_stage: data-cache pipeline stage feeding the write-back register.
// Direct-mapped, write-through, no-write-allocate; 4 x 16-bit words per line,
// filled over a req/ack memory port. Non-memory ops pass alu_result through.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module cache_stage #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_cache,
  input  logic [15:0] alu_result,
  input  logic [15:0] store_data,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        word_access,
  input  logic [2:0]  destReg_addr_input,
  input  logic        we_input,
  input  logic [1:0]  bp_input,
  output logic [15:0] cache_result,
  output logic [2:0]  destReg_addr_output,
  output logic        we_output,
  output logic [1:0]  bp_output,
  output logic        word_access_from_cache,
  output logic        cache_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state_q, state_d;

  logic [63:0]      data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word_off;
  logic             hit, load_op, store_op, fill_done, store_hit;
  logic [63:0]      line_sel, store_line;
  logic [15:0]      word_sel;

  assign idx      = alu_result[2+IDX_W:3];
  assign tag      = alu_result[ADDR_W-1:3+IDX_W];
  assign word_off = alu_result[2:1];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  // Both kinds high behaves as a store.
  assign load_op  = enable_cache & is_load & ~is_store;
  assign store_op = enable_cache & is_store;
  assign fill_done = (state_q == FILL) & mem_ack;
  assign store_hit = (state_q == IDLE) & store_op & hit;

  // Pass-through sideband; write enable suppressed while the stage is held.
  assign destReg_addr_output    = destReg_addr_input;
  assign bp_output              = bp_input;
  assign word_access_from_cache = word_access;
  assign we_output              = we_input & ~cache_stall;

  // Hold the pipeline on a load miss or any store until memory acknowledges.
  assign cache_stall = ((state_q == IDLE) & ((load_op & ~hit) | store_op))
                     | ((state_q != IDLE) & ~mem_ack);

  // Load data: the returning fill line bypasses the array in the ack cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    line_sel     = fill_done ? mem_rdata : data_q[idx];
    word_sel     = line_sel[{word_off, 4'b0000} +: 16];
    cache_result = alu_result;
    if (load_op)
      cache_result = word_access ? word_sel
                                 : {8'h00, word_sel[{alu_result[0], 3'b000} +: 8]};
  end

  // Line image after merging a store hit's byte/word.
  always_comb begin
    store_line = data_q[idx];
    if (word_access)
      store_line[{word_off, 4'b0000} +: 16] = store_data;
    else
      store_line[{word_off, alu_result[0], 3'b000} +: 8] = store_data[7:0];
  end

  // Next-state: fill on load miss, write-through on every store.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (store_op)               state_d = WRITE;
        else if (load_op && !hit)   state_d = FILL;
      end
      FILL, WRITE: if (mem_ack)     state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // State and registered memory request; request fields captured on entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state_q <= state_d;
      mem_req <= (state_d != IDLE);
      if (state_q == IDLE && state_d != IDLE) begin
        mem_we    <= store_op;
        mem_addr  <= store_op ? alu_result : {alu_result[15:3], 3'b000};
        if (word_access) begin
          mem_wdata <= store_data;
          mem_be    <= 2'b11;
        end else begin
          mem_wdata <= alu_result[0] ? {store_data[7:0], 8'h00} : {8'h00, store_data[7:0]};
          mem_be    <= alu_result[0] ? 2'b10 : 2'b01;
        end
      end
    end
  end

  // Valid bits: cleared by reset, set when a fill completes.
  always_ff @(posedge clk) begin
    if (reset)          valid_q      <= '0;
    else if (fill_done) valid_q[idx] <= 1'b1;
  end

  // Data and tag arrays: line fill on ack, in-place merge on a store hit.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are not reset; cleared valid bits make their contents
    // irrelevant, and the reset gate keeps an aborted fill from writing.
    if (!reset) begin
      if (fill_done) begin
        data_q[idx] <= mem_rdata;
        tag_q[idx]  <= tag;
      end else if (store_hit) begin
        data_q[idx] <= store_line;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating load statistics: hits on lookup, misses on fill entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == IDLE && load_op) begin
      if (hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      else if (!hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
